// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: divides CLOCK_50 down to a pixel enable and drives
// registered sync/blank/colour, plus a look-ahead coordinate and frame/line strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int LEAD     = 1,
  parameter int COLOR_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [10:0]        next_x,
  output logic [10:0]        next_y,
  output logic               next_valid,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [4:0]  DIV_HALF = 5'(CLK_DIV / 2);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  // Wrap subtraction is done modulo 2048, so H_TOTAL=2048 truncating to zero is harmless
  localparam logic [10:0] H_TOT_M  = 11'(H_TOTAL);
  localparam logic [11:0] H_TOT_W  = 12'(H_TOTAL);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG_W = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_W = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG_W = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_W = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] LEAD_W   = 12'(LEAD);
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  logic [4:0]         div_r;
  logic [10:0]        h_r;
  logic [10:0]        v_r;
  logic               pix_ce_s;
  logic               vclk_s;
  logic [11:0]        h_ext_s;
  logic [11:0]        v_ext_s;
  logic               active_s;
  logic               hs_s;
  logic               vs_s;
  logic [11:0]        look_s;
  logic [10:0]        nx_s;
  logic [10:0]        ny_s;
  logic               nvalid_s;
  logic               vga_clk_r;
  logic               hs_r;
  logic               vs_r;
  logic               blank_n_r;
  logic [COLOR_W-1:0] r_r;
  logic [COLOR_W-1:0] g_r;
  logic [COLOR_W-1:0] b_r;
  logic               frame_start_r;
  logic               line_start_r;

  assign pix_ce_s = (div_r == DIV_LAST);
  assign vclk_s   = (div_r >= DIV_HALF);

  // Pixel-clock divider and the DAC clock derived from it
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_r     <= 5'd0;
      vga_clk_r <= 1'b0;
    end else begin
      vga_clk_r <= vclk_s;
      if (pix_ce_s) begin
        div_r <= 5'd0;
      end else begin
        div_r <= div_r + 5'd1;
      end
    end
  end

  // Horizontal and vertical position counters
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      h_r <= 11'd0;
      v_r <= 11'd0;
    end else if (pix_ce_s) begin
      if (h_r == H_LAST) begin
        h_r <= 11'd0;
        if (v_r == V_LAST) begin
          v_r <= 11'd0;
        end else begin
          v_r <= v_r + 11'd1;
        end
      end else begin
        h_r <= h_r + 11'd1;
      end
    end
  end

  // Sync and active-area decode of the current position
  always_comb begin
    h_ext_s  = {1'b0, h_r};
    v_ext_s  = {1'b0, v_r};
    active_s = (h_ext_s < H_ACT_W) && (v_ext_s < V_ACT_W);
    if ((h_ext_s >= HS_BEG_W) && (h_ext_s < HS_END_W)) begin
      hs_s = HS_ACT;
    end else begin
      hs_s = ~HS_ACT;
    end
    if ((v_ext_s >= VS_BEG_W) && (v_ext_s < VS_END_W)) begin
      vs_s = VS_ACT;
    end else begin
      vs_s = ~VS_ACT;
    end
  end

  // Look-ahead coordinate, LEAD pixels ahead of the counters with line/frame wrap
  always_comb begin
    look_s = h_ext_s + LEAD_W;
    nx_s   = look_s[10:0];
    ny_s   = v_r;
    if (look_s < H_TOT_W) begin
      nx_s = look_s[10:0];
      ny_s = v_r;
    end else begin
      nx_s = look_s[10:0] - H_TOT_M;
      if (v_r == V_LAST) begin
        ny_s = 11'd0;
      end else begin
        ny_s = v_r + 11'd1;
      end
    end
    nvalid_s = ({1'b0, nx_s} < H_ACT_W) && ({1'b0, ny_s} < V_ACT_W);
  end

  // Output registers load on the pixel enable; strobes last one CLOCK_50 cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hs_r          <= ~HS_ACT;
      vs_r          <= ~VS_ACT;
      blank_n_r     <= 1'b0;
      r_r           <= {COLOR_W{1'b0}};
      g_r           <= {COLOR_W{1'b0}};
      b_r           <= {COLOR_W{1'b0}};
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
    end else begin
      line_start_r  <= pix_ce_s && (h_r == 11'd0);
      frame_start_r <= pix_ce_s && (h_r == 11'd0) && (v_r == 11'd0);
      if (pix_ce_s) begin
        hs_r      <= hs_s;
        vs_r      <= vs_s;
        blank_n_r <= active_s;
        r_r       <= active_s ? red_in   : {COLOR_W{1'b0}};
        g_r       <= active_s ? green_in : {COLOR_W{1'b0}};
        b_r       <= active_s ? blue_in  : {COLOR_W{1'b0}};
      end
    end
  end

  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_R       = r_r;
  assign VGA_G       = g_r;
  assign VGA_B       = b_r;
  assign VGA_BLANK_N = blank_n_r;
  assign VGA_SYNC_N  = 1'b0;
  assign next_x      = nx_s;
  assign next_y      = ny_s;
  assign next_valid  = nvalid_s;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a small odd-polarity config and a
// LEAD=3 instance fed by a three-stage pixel source returning next_x as red.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc;
  int   tests = 0;
  int   fails = 0;

  // Default instance
  logic        d_clk, d_hs, d_vs, d_blank, d_sync_n, d_nv, d_fs, d_ls;
  logic [7:0]  d_r, d_g, d_b;
  logic [10:0] d_nx, d_ny;

  vga_timing_gen u_def (
    .CLOCK_50(clk), .reset(rst_a),
    .red_in(8'hAA), .green_in(8'h55), .blue_in(8'h0F),
    .VGA_CLK(d_clk), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_sync_n),
    .next_x(d_nx), .next_y(d_ny), .next_valid(d_nv),
    .frame_start(d_fs), .line_start(d_ls)
  );

  // Small config, active-high syncs, CLK_DIV=3
  logic        s_clk, s_hs, s_vs, s_blank, s_sync_n, s_nv, s_fs, s_ls;
  logic [7:0]  s_r, s_g, s_b;
  logic [10:0] s_nx, s_ny;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(3), .LEAD(1)
  ) u_small (
    .CLOCK_50(clk), .reset(rst_b),
    .red_in(8'h5A), .green_in(8'h3C), .blue_in(8'hC3),
    .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync_n),
    .next_x(s_nx), .next_y(s_ny), .next_valid(s_nv),
    .frame_start(s_fs), .line_start(s_ls)
  );

  // LEAD=3 instance, default horizontal timing, short frame (V_TOTAL=7)
  logic        l_clk, l_hs, l_vs, l_blank, l_sync_n, l_nv, l_fs, l_ls;
  logic [10:0] l_r, l_g, l_b, l_red;
  logic [10:0] l_nx, l_ny;

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LEAD(3), .COLOR_W(11)
  ) u_l3 (
    .CLOCK_50(clk), .reset(rst_b),
    .red_in(l_red), .green_in(11'd0), .blue_in(11'd0),
    .VGA_CLK(l_clk), .VGA_HS(l_hs), .VGA_VS(l_vs),
    .VGA_R(l_r), .VGA_G(l_g), .VGA_B(l_b),
    .VGA_BLANK_N(l_blank), .VGA_SYNC_N(l_sync_n),
    .next_x(l_nx), .next_y(l_ny), .next_valid(l_nv),
    .frame_start(l_fs), .line_start(l_ls)
  );

  // Bench pixel source: own divide-by-2 enable and a three-stage pipeline of next_x
  logic [4:0]  m_div;
  logic [10:0] p1, p2, p3;
  always_ff @(posedge clk) begin
    if (rst_b) begin
      m_div <= 5'd0;
    end else if (m_div == 5'd1) begin
      m_div <= 5'd0;
      p1    <= l_nx;
      p2    <= p1;
      p3    <= p2;
    end else begin
      m_div <= m_div + 5'd1;
    end
  end
  assign l_red = p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  int s_hs_hi, s_vs_hi, s_fs_n, s_ls_n, s_clk_bad;
  int d_hs_lo, d_blank_n, d_r_aa, d_r_bad, d_clk_bad;
  int l_act, l_bad;
  int n, eh, ev;
  logic eact;

  initial begin
    s_hs_hi = 0; s_vs_hi = 0; s_fs_n = 0; s_ls_n = 0; s_clk_bad = 0;
    d_hs_lo = 0; d_blank_n = 0; d_r_aa = 0; d_r_bad = 0; d_clk_bad = 0;
    l_act = 0; l_bad = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    cyc   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("def_rst_hs", d_hs, 1'b1);
    chk("def_rst_vs", d_vs, 1'b1);
    chk("def_rst_r", d_r, 8'h00);
    chk("def_rst_blank", d_blank, 1'b0);
    chk("def_rst_clk", d_clk, 1'b0);
    chk("def_rst_fs", d_fs, 1'b0);
    chk("def_rst_ls", d_ls, 1'b0);
    chk("def_rst_nx", d_nx, 11'd1);
    chk("def_rst_ny", d_ny, 11'd0);
    chk("def_rst_nv", d_nv, 1'b1);
    chk("def_sync_n", d_sync_n, 1'b0);
    chk("small_rst_hs", s_hs, 1'b0);
    chk("small_rst_vs", s_vs, 1'b0);
    chk("l3_rst_nx", l_nx, 11'd3);

    // Small config frame plus default first-pixel strobes
    for (int c = 1; c < 440; c++) begin
      tick();
      if (cyc >= 36 && cyc < 72 && s_hs === 1'b1) s_hs_hi++;
      if (cyc < 252 && s_vs === 1'b1) s_vs_hi++;
      if (s_fs !== 1'b0) s_fs_n++;
      if (s_ls !== 1'b0) s_ls_n++;
      if (s_clk !== ((cyc % 3 == 1) ? 1'b0 : 1'b1)) s_clk_bad++;
      if (cyc == 1) chk("def_fs_c1", d_fs, 1'b0);
      if (cyc == 2) begin
        chk("def_fs_first", d_fs, 1'b1);
        chk("def_ls_first", d_ls, 1'b1);
        chk("def_blank_first", d_blank, 1'b1);
        chk("def_r_first", d_r, 8'hAA);
        chk("def_g_first", d_g, 8'h55);
      end
      if (cyc == 3) begin
        chk("def_fs_c3", d_fs, 1'b0);
        chk("small_fs_first", s_fs, 1'b1);
        chk("small_ls_first", s_ls, 1'b1);
      end
      if (cyc == 21) begin
        chk("small_nx_7", s_nx, 11'd8);
        chk("small_nv_7", s_nv, 1'b0);
      end
      if (cyc == 24) begin
        chk("small_r_h7", s_r, 8'h5A);
        chk("small_b_h7", s_b, 8'hC3);
      end
      if (cyc == 27) begin
        chk("small_r_h8", s_r, 8'h00);
        chk("small_blank_h8", s_blank, 1'b0);
      end
      if (cyc == 29) chk("small_hs_c29", s_hs, 1'b0);
      if (cyc == 30) chk("small_hs_c30", s_hs, 1'b1);
      if (cyc == 35) chk("small_hs_c35", s_hs, 1'b1);
      if (cyc == 36) chk("small_hs_c36", s_hs, 1'b0);
      if (cyc == 66) chk("small_hs_c66", s_hs, 1'b1);
      if (cyc == 105) begin
        chk("small_nx_11_2", s_nx, 11'd0);
        chk("small_ny_11_2", s_ny, 11'd3);
        chk("small_nv_11_2", s_nv, 1'b1);
      end
      if (cyc == 132) chk("small_blank_7_3", s_blank, 1'b1);
      if (cyc == 141) begin
        chk("small_ny_11_3", s_ny, 11'd4);
        chk("small_nv_11_3", s_nv, 1'b0);
      end
      if (cyc == 147) chk("small_blank_0_4", s_blank, 1'b0);
      if (cyc == 182) chk("small_vs_c182", s_vs, 1'b0);
      if (cyc == 183) chk("small_vs_c183", s_vs, 1'b1);
      if (cyc == 218) chk("small_vs_c218", s_vs, 1'b1);
      if (cyc == 219) chk("small_vs_c219", s_vs, 1'b0);
      if (cyc == 249) begin
        chk("small_nx_wrap", s_nx, 11'd0);
        chk("small_ny_wrap", s_ny, 11'd0);
        chk("small_nv_wrap", s_nv, 1'b1);
      end
      if (cyc == 255) chk("small_fs_frame2", s_fs, 1'b1);
      if (cyc == 434) chk("small_vs_c434", s_vs, 1'b0);
      if (cyc == 435) chk("small_vs_c435", s_vs, 1'b1);
    end
    chk("small_hs_width", s_hs_hi, 6);
    chk("small_vs_width", s_vs_hi, 36);
    chk("small_fs_count", s_fs_n, 2);
    chk("small_ls_count", s_ls_n, 13);
    chk("small_vgaclk_pattern", s_clk_bad, 0);

    // Look-ahead around the end of the active line
    run_to(1272);
    chk("l3_nx_636", l_nx, 11'd639);
    chk("l3_nv_636", l_nv, 1'b1);
    run_to(1274);
    chk("l3_nx_637", l_nx, 11'd640);
    chk("l3_nv_637", l_nv, 1'b0);
    run_to(1276);
    chk("def_nv_638", d_nv, 1'b1);
    run_to(1278);
    chk("def_nx_639", d_nx, 11'd640);
    chk("def_ny_639", d_ny, 11'd0);
    chk("def_nv_639", d_nv, 1'b0);
    run_to(1313);
    chk("def_hs_c1313", d_hs, 1'b1);
    run_to(1314);
    chk("def_hs_c1314", d_hs, 1'b0);
    run_to(1505);
    chk("def_hs_c1505", d_hs, 1'b0);
    run_to(1506);
    chk("def_hs_c1506", d_hs, 1'b1);

    // One full line window (v=1) on the default and LEAD=3 instances
    run_to(1599);
    for (int c = 0; c < 1600; c++) begin
      tick();
      if (d_hs === 1'b0) d_hs_lo++;
      if (d_blank === 1'b1) d_blank_n++;
      if (d_r === 8'hAA) d_r_aa++;
      if (d_r !== ((d_blank === 1'b1) ? 8'hAA : 8'h00)) d_r_bad++;
      if (d_clk !== ((cyc % 2 == 0) ? 1'b1 : 1'b0)) d_clk_bad++;
      n    = cyc / 2 - 1;
      eh   = n % 800;
      ev   = (n / 800) % 7;
      eact = (eh < 640) && (ev < 4);
      if (eact) l_act++;
      if (l_blank !== eact) l_bad++;
      else if (l_r !== (eact ? 11'(eh) : 11'd0)) l_bad++;
      if (cyc == 1602) chk("l3_r_h0", l_r, 11'd0);
      if (cyc == 2880) chk("l3_r_h639", l_r, 11'd639);
      if (cyc == 2913) chk("def_hs_c2913", d_hs, 1'b1);
      if (cyc == 2914) chk("def_hs_c2914", d_hs, 1'b0);
    end
    chk("def_hs_low_per_line", d_hs_lo, 192);
    chk("def_blank_per_line", d_blank_n, 1280);
    chk("def_r_aa_per_line", d_r_aa, 1280);
    chk("def_r_window", d_r_bad, 0);
    chk("def_vgaclk_period", d_clk_bad, 0);
    chk("l3_active_cycles", l_act, 1280);
    chk("l3_r_tracks_h", l_bad, 0);

    // Vertical wrap of the look-ahead with LEAD=3
    run_to(11198);
    chk("l3_nx_799_6", l_nx, 11'd2);
    chk("l3_ny_799_6", l_ny, 11'd0);
    chk("l3_nv_799_6", l_nv, 1'b1);

    run_to(17596);
    chk("def_nx_798_10", d_nx, 11'd799);
    chk("def_nv_798_10", d_nv, 1'b0);
    run_to(17598);
    chk("def_nx_799_10", d_nx, 11'd0);
    chk("def_ny_799_10", d_ny, 11'd11);
    chk("def_nv_799_10", d_nv, 1'b1);

    // Mid-line reset at (300,11)
    run_to(18200);
    chk("def_pre_rst_blank", d_blank, 1'b1);
    chk("def_pre_rst_nx", d_nx, 11'd301);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("def_mid_rst_blank", d_blank, 1'b0);
    chk("def_mid_rst_r", d_r, 8'h00);
    chk("def_mid_rst_hs", d_hs, 1'b1);
    chk("def_mid_rst_clk", d_clk, 1'b0);
    chk("def_mid_rst_fs", d_fs, 1'b0);
    chk("def_mid_rst_nx", d_nx, 11'd1);
    chk("def_mid_rst_ny", d_ny, 11'd0);
    tick();
    chk("def_post_rst_fs1", d_fs, 1'b0);
    tick();
    chk("def_post_rst_fs2", d_fs, 1'b1);
    chk("def_post_rst_r", d_r, 8'hAA);
    tick();
    chk("def_post_rst_fs3", d_fs, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
